// File: rtl/result_writeback_simd.sv
// SIMD write-back of the downscaled image into BRAM, N pixels per beat in raster order.
// Optional running checksum of written pixels is built when WB_CHECKSUM_EN is defined.
module result_writeback_simd #(
  parameter int DST_W     = 16,
  parameter int DST_H     = 16,
  parameter int N         = 4,
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_BITS = 11
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [0:DST_H-1][0:DST_W-1][7:0]       image_in,
  output logic [N-1:0]                           wr_req,
  output logic [N-1:0][ADDR_BITS-1:0]            wr_addr,
  output logic [N-1:0][7:0]                      wr_data,
  input  logic                                   wr_ack,
  output logic                                   busy,
  output logic                                   done,
  output logic [15:0]                            checksum
);

  localparam int DEPTH = DST_W * DST_H;
  localparam int IW    = ADDR_BITS + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH_L = IW'(DEPTH);
  localparam logic [IW-1:0] BASE_L  = IW'(BASE_ADDR);
  localparam logic [IW-1:0] N_L     = IW'(N);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d, ld_idx;
  logic [N-1:0]                 req_q, req_d, ld_req;
  logic [N-1:0][ADDR_BITS-1:0]  addr_q, addr_d, ld_addr;
  logic [N-1:0][7:0]            data_q, data_d, ld_data;
  logic                         busy_q, busy_d, done_q, done_d;
  logic                         last_beat;
  logic [7:0]                   pix [DEPTH];

  for (genvar r = 0; r < DST_H; r++) begin : g_row
    for (genvar c = 0; c < DST_W; c++) begin : g_col
      assign pix[r*DST_W + c] = image_in[r][c];
    end
  end

  // Beat to present next: beat 0 when leaving IDLE, otherwise the one after idx_q.
  assign ld_idx    = (state_q == S_IDLE) ? '0 : idx_q + N_L;
  assign last_beat = (idx_q + N_L) >= DEPTH_L;

  always_comb begin
    ld_req  = '0;
    ld_addr = '0;
    ld_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ld_idx) + k < DEPTH) begin
        ld_req[k]  = 1'b1;
        ld_addr[k] = ADDR_BITS'(BASE_L + ld_idx + IW'(k));
        ld_data[k] = pix[PW'(int'(ld_idx) + k)];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          idx_d   = '0;
          req_d   = ld_req;
          addr_d  = ld_addr;
          data_d  = ld_data;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          if (last_beat) begin
            state_d = S_DONE;
            req_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = ld_idx;
            req_d  = ld_req;
            addr_d = ld_addr;
            data_d = ld_data;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef WB_CHECKSUM_EN
  logic [15:0] csum_q, csum_d, beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (req_q[k]) beat_sum = beat_sum + 16'(data_q[k]);
    end
  end

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && start)       csum_d = '0;
    else if (state_q == S_WRITE && wr_ack) csum_d = csum_q + beat_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign wr_req  = req_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_result_writeback_simd.sv
// Directed bench for result_writeback_simd: a 16x16 instance and a 5x3 partial-beat instance.
module tb_result_writeback_simd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16x16 instance
  logic                      start, wr_ack, busy, done;
  logic [0:15][0:15][7:0]    img1;
  logic [3:0]                wr_req;
  logic [3:0][10:0]          wr_addr;
  logic [3:0][7:0]           wr_data;
  logic [15:0]               checksum;

  // 5x3 instance
  logic                      start2, wr_ack2, busy2, done2;
  logic [0:2][0:4][7:0]      img2;
  logic [3:0]                wr_req2;
  logic [3:0][10:0]          wr_addr2;
  logic [3:0][7:0]           wr_data2;
  logic [15:0]               checksum2;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef WB_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM1 = 16'h7F80;
  localparam logic [15:0] EXP_SUM2 = 16'd1605;
`else
  localparam logic [15:0] EXP_SUM1 = 16'h0000;
  localparam logic [15:0] EXP_SUM2 = 16'h0000;
`endif

  result_writeback_simd u_dut (
    .clk(clk), .rst(rst), .start(start), .image_in(img1),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .checksum(checksum)
  );

  result_writeback_simd #(.DST_W(5), .DST_H(3)) u_small (
    .clk(clk), .rst(rst), .start(start2), .image_in(img2),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2),
    .busy(busy2), .done(done2), .checksum(checksum2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Runs one full 64-beat transfer on the 16x16 instance, optionally stalling one beat.
  task automatic run_transfer(input int stall_beat, input int stall_len, input bit hold_start);
    int beat = 0;
    int stall = 0;
    int done_cyc = 0;
    start  = 1'b1;
    wr_ack = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
`ifndef WB_CHECKSUM_EN
      check("csum_tied_zero", checksum, 0);
`endif
      if (wr_req == 4'h0) begin
        check("wr_req_gap", wr_req, 4'hF);
      end else begin
        check("beat_req", wr_req, 4'hF);
        check("beat_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
          check("beat_addr", 32'(wr_addr[k]), 1024 + 4*beat + k);
          check("beat_data", 32'(wr_data[k]), (4*beat + k) % 256);
        end
        if (beat == stall_beat && stall < stall_len) begin
          wr_ack = 1'b0;
          stall++;
        end else begin
          wr_ack = 1'b1;
          beat++;
        end
      end
    end
    wr_ack = 1'b1;
    check("beat_count", beat, 64);
    check("done_cycle", done_cyc, 65 + stall_len);
    check("busy_at_done", busy, 0);
    check("checksum_final", checksum, EXP_SUM1);
  endtask

  initial begin
    bit found;
    int beat2, dc2;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img1[r][c] = 8'(r*16 + c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) img2[r][c] = 8'(100 + r*5 + c);

    rst = 1'b1; start = 1'b0; wr_ack = 1'b1; start2 = 1'b0; wr_ack2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", 32'(wr_addr[0]), 0);
    check("rst_wr_data", 32'(wr_data[3]), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    rst = 1'b0;

    // wr_ack high in IDLE must do nothing
    repeat (2) @(posedge clk);
    #1;
    check("idle_ack_req", wr_req, 0);
    check("idle_ack_busy", busy, 0);

    // Back-to-back transfer, then a 3-cycle stall on beat 5
    run_transfer(-1, 0, 1'b0);
    @(posedge clk); #1;
    check("idle_after_done", done, 0);
    run_transfer(5, 3, 1'b0);
    @(posedge clk); #1;

    // Reset while beat 20 is on the bus, then restart from address 1024
    found = 1'b0;
    start = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wr_req != 0 && 32'(wr_addr[0]) == 1024 + 80) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_beat20", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_wr_req", wr_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", 32'(wr_addr[1]), 0);
    @(posedge clk); #1;
    check("abort_stays_idle", wr_req, 0);
    run_transfer(-1, 0, 1'b0);
    @(posedge clk); #1;

    // start held through DONE: no restart until it drops
    run_transfer(-1, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold_done", done, 1);
      check("hold_no_req", wr_req, 0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("release_done", done, 0);
    run_transfer(-1, 0, 1'b0);

    // 5x3 image: 15 pixels, last beat has only three lanes
    beat2 = 0;
    dc2   = 0;
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (done2) begin
        dc2 = cyc;
        break;
      end
      if (wr_req2 != 0) begin
        check("small_req", wr_req2, (beat2 < 3) ? 4'hF : 4'h7);
        for (int k = 0; k < 4; k++) begin
          if (4*beat2 + k < 15) begin
            check("small_addr", 32'(wr_addr2[k]), 1024 + 4*beat2 + k);
            check("small_data", 32'(wr_data2[k]), 100 + 4*beat2 + k);
          end
        end
        beat2++;
      end
    end
    check("small_beats", beat2, 4);
    check("small_done_cycle", dc2, 5);
    check("small_busy_at_done", busy2, 0);
    check("small_checksum", checksum2, EXP_SUM2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
